mmc1_config_sequencer: RTL

Bus-master sequencer that programs the MMC1 mapper's serial registers from a simple command interface. It turns one 5-bit register write into the 5-write serial protocol, and inserts the read cycle the mapper needs between consecutive writes. It generates CPU-style bus cycles (m2, R/W, /ROMSEL, A14, A13, D7, D0) on the cartridge-side bus. Used by the loader/self-test path to configure banking before the CPU is released.

---
 rtl/mmc1_config_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mmc1_config_sequencer.sv
// MMC1 serial-register programmer: expands one 5-bit register write (or a mapper
// reset) into the mapper's alternating read/write bus-cycle sequence on a generated m2.
module mmc1_config_sequencer #(
  parameter int unsigned HALF = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_reset,
  input  logic [1:0] cmd_reg,
  input  logic [4:0] cmd_data,
  output logic       done,
  output logic       busy,
  output logic       bus_m2,
  output logic       bus_rw,
  output logic       bus_romsel,
  output logic       bus_a14,
  output logic       bus_a13,
  output logic       bus_d7,
  output logic       bus_d0,
  output logic       bus_d_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SETUP,
    S_HIGH,
    S_HOLD
  } state_t;

  typedef struct packed {
    logic rw;
    logic romsel;
    logic a14;
    logic a13;
    logic d7;
    logic d0;
    logic d_oe;
  } bus_t;

  localparam bus_t BUS_IDLE = '{rw: 1'b1, romsel: 1'b1, a14: 1'b0, a13: 1'b0,
                                d7: 1'b0, d0: 1'b0, d_oe: 1'b0};
  localparam logic [3:0] PHASE_LAST     = 4'(HALF - 1);
  localparam logic [3:0] IDX_LAST_RESET = 4'd1;
  localparam logic [3:0] IDX_LAST_REG   = 4'd9;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [3:0] r_idx;
  logic       r_is_reset;
  logic [1:0] r_reg;
  logic [4:0] r_shift;
  bus_t       r_bus;
  logic       r_m2;
  logic       r_ready;
  logic       r_busy;
  logic       r_done;

  logic [3:0] w_next_idx;
  logic       w_last;
  bus_t       w_setup;

  // Bus values for the cycle that starts on the next edge: from START that is
  // cycle 0, from HOLD it is the one after the cycle now finishing.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_idx = (r_state == S_START) ? 4'd0 : r_idx + 4'd1;
    w_last     = (r_idx == (r_is_reset ? IDX_LAST_RESET : IDX_LAST_REG));
    w_setup        = BUS_IDLE;
    w_setup.romsel = 1'b0;
    if (w_next_idx[0]) begin
      w_setup.rw   = 1'b0;
      w_setup.d_oe = 1'b1;
      if (r_is_reset) begin
        w_setup.d7 = 1'b1;
      end else begin
        {w_setup.a14, w_setup.a13} = r_reg;
        w_setup.d0                 = r_shift[0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset branch is
  // synchronous and clears every register, since the block has no memories to exempt.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_is_reset <= 1'b0;
      r_reg      <= '0;
      r_shift    <= '0;
      r_bus      <= BUS_IDLE;
      r_m2       <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_ready) begin
            r_is_reset <= cmd_reset;
            r_reg      <= cmd_reg;
            r_shift    <= cmd_data;
            r_idx      <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_START;
          end
        end

        S_START: begin
          r_bus   <= w_setup;
          r_idx   <= w_next_idx;
          r_cnt   <= PHASE_LAST;
          r_state <= S_SETUP;
        end

        S_SETUP: begin
          if (r_cnt == '0) begin
            r_m2    <= 1'b1;
            r_cnt   <= PHASE_LAST;
            r_state <= S_HIGH;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_HIGH: begin
          if (r_cnt == '0) begin
            r_m2    <= 1'b0;
            r_state <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_HOLD: begin
          // A finished write consumes one data bit, so r_shift[0] is always the next bit.
          if (r_idx[0]) begin
            r_shift <= {1'b0, r_shift[4:1]};
          end
          if (w_last) begin
            r_bus   <= BUS_IDLE;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_bus   <= w_setup;
            r_idx   <= w_next_idx;
            r_cnt   <= PHASE_LAST;
            r_state <= S_SETUP;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = r_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign bus_m2     = r_m2;
  assign bus_rw     = r_bus.rw;
  assign bus_romsel = r_bus.romsel;
  assign bus_a14    = r_bus.a14;
  assign bus_a13    = r_bus.a13;
  assign bus_d7     = r_bus.d7;
  assign bus_d0     = r_bus.d0;
  assign bus_d_oe   = r_bus.d_oe;

endmodule
